pwm_decoder: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and recovers its high time and period in clk cycles.
- Lets a board loop a generated PWM back for self-check, or read external PWM sources (sensors, RC inputs) as numeric values.
- Sits between an unsynchronised input pin and downstream logic; publishes one measurement per PWM period with a single-cycle valid strobe.

---
 rtl/pwm_decoder.sv | 155 +++++++++++++++
 tb/tb_pwm_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM receiver: measures high time and rise-to-rise period of an asynchronous PWM input in clk cycles.
// Optional deglitch stage after the synchroniser is enabled by defining PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder #(
    parameter int MAX_PERIOD = 4096,
    parameter int FILTER_LEN = 4,
    localparam int CW = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] high_cycles,
    output logic [CW-1:0] period_cycles,
    output logic          meas_valid,
    output logic          timeout,
    output logic          stuck_level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PERIOD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (FILTER_LEN < 1 || MAX_PERIOD < 2) begin : g_bad_params
        $error("pwm_decoder: FILTER_LEN must be >= 1 and MAX_PERIOD >= 2");
    end

    logic sync_q1;
    logic sync_q2;
    logic lvl;
    logic lvl_d;
    logic rise;
    logic fall;
    logic at_max;

    logic [1:0]    state;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] pcnt;

    // NOTE: sequential state uses non-blocking assignments so each flop samples the pre-edge value of its source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic          filt;
    logic [FW-1:0] fcnt;

    // The filtered level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (sync_q2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= sync_q2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync_q2;
`endif

    assign rise   = lvl & ~lvl_d;
    assign fall   = ~lvl & lvl_d;
    assign at_max = (pcnt == CNT_MAX);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d         <= 1'b0;
            state         <= ST_IDLE;
            hcnt          <= '0;
            pcnt          <= '0;
            high_cycles   <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            timeout       <= 1'b0;
            stuck_level   <= 1'b0;
        end else begin
            lvl_d      <= lvl;
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hcnt <= '0;
                    pcnt <= '0;
                    if (rise) begin
                        state   <= ST_HIGH;
                        hcnt    <= CNT_ONE;
                        pcnt    <= CNT_ONE;
                        timeout <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (at_max) begin
                        state       <= ST_IDLE;
                        hcnt        <= '0;
                        pcnt        <= '0;
                        timeout     <= 1'b1;
                        stuck_level <= lvl;
                    end else begin
                        pcnt <= sat_inc(pcnt);
                        if (fall) begin
                            state <= ST_LOW;
                        end else begin
                            hcnt <= sat_inc(hcnt);
                        end
                    end
                end
                ST_LOW: begin
                    // A rise on the saturation cycle still closes a valid period.
                    if (rise) begin
                        high_cycles   <= hcnt;
                        period_cycles <= pcnt;
                        meas_valid    <= 1'b1;
                        state         <= ST_HIGH;
                        hcnt          <= CNT_ONE;
                        pcnt          <= CNT_ONE;
                    end else if (at_max) begin
                        state       <= ST_IDLE;
                        hcnt        <= '0;
                        pcnt        <= '0;
                        timeout     <= 1'b1;
                        stuck_level <= lvl;
                    end else begin
                        pcnt <= sat_inc(pcnt);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    hcnt  <= '0;
                    pcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: clean periods, duty changes, timeouts, async reset, glitch and boundary periods.
module tb_pwm_decoder;

    localparam int MAX_PERIOD = 4096;
    localparam int CW = $clog2(MAX_PERIOD + 1);

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 6;
    localparam int N_AFTER_GLITCH = 14;
`else
    localparam int LAT = 2;
    localparam int N_AFTER_GLITCH = 15;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] high_cycles;
    logic [CW-1:0] period_cycles;
    logic          meas_valid;
    logic          timeout;
    logic          stuck_level;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    logic [31:0] cap_h [64];
    logic [31:0] cap_p [64];

    pwm_decoder #(.MAX_PERIOD(MAX_PERIOD), .FILTER_LEN(4)) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .high_cycles(high_cycles),
        .period_cycles(period_cycles),
        .meas_valid(meas_valid),
        .timeout(timeout),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    // Log every strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            if (n_valid < 64) begin
                cap_h[n_valid] = 32'(high_cycles);
                cap_p[n_valid] = 32'(period_cycles);
            end
            n_valid = n_valid + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp)
        else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic pulse(input int h, input int p);
        drive(1'b1, h);
        drive(1'b0, p - h);
    endtask

    task automatic check_meas(input string tag, input int idx, input int h, input int p);
        check({tag, "_high"}, (idx < 64) ? cap_h[idx] : 32'hFFFF_FFFF, 32'(h));
        check({tag, "_period"}, (idx < 64) ? cap_p[idx] : 32'hFFFF_FFFF, 32'(p));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            cap_h[i] = '0;
            cap_p[i] = '0;
        end
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_high", 32'(high_cycles), 0);
        check("rst_period", 32'(period_cycles), 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_stuck", 32'(stuck_level), 0);
        rst = 1'b0;

        // Idle low from reset: no strobe, no timeout.
        drive(1'b0, 5000);
        check("idle_low_nvalid", 32'(n_valid), 0);
        check("idle_low_timeout", 32'(timeout), 0);

        // First period only arms; the second rise reports it.
        pulse(301, 1200);
        check("arm_nvalid", 32'(n_valid), 0);
        pulse(301, 1200);
        check("p1_nvalid", 32'(n_valid), 1);
        check_meas("p1", 0, 301, 1200);

        // Latency and single-cycle strobe on the rise that closes period 2.
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (LAT) @(posedge clk);
        #1 check("lat_early", 32'(meas_valid), 0);
        @(posedge clk);
        #1 check("lat_strobe", 32'(meas_valid), 1);
        check("lat_high", 32'(high_cycles), 301);
        check("lat_period", 32'(period_cycles), 1200);
        @(posedge clk);
        #1 check("lat_one_cycle", 32'(meas_valid), 0);
        drive(1'b1, 301 - (LAT + 2));
        drive(1'b0, 899);

        // Duty change, then short periods down to a 4-cycle high.
        pulse(900, 1200);
        pulse(900, 1200);
        check_meas("manual", 2, 301, 1200);
        check_meas("duty900", 3, 900, 1200);
        check("duty_timeout", 32'(timeout), 0);
        pulse(5, 20);
        pulse(4, 8);
        pulse(4, 8);
        pulse(6, 10);
        check_meas("short5", 5, 5, 20);
        check_meas("short4", 6, 4, 8);
        check("short_nvalid", 32'(n_valid), 8);

        // Stuck high from a running state.
        drive(1'b1, 4000);
        check("stuckh_pre_timeout", 32'(timeout), 0);
        drive(1'b1, 200);
        check("stuckh_timeout", 32'(timeout), 1);
        check("stuckh_level", 32'(stuck_level), 1);
        check("stuckh_hold_high", 32'(high_cycles), 6);
        check("stuckh_hold_period", 32'(period_cycles), 10);
        check("stuckh_nvalid", 32'(n_valid), 9);

        // Recovery: rise clears timeout, first report one period later.
        drive(1'b0, 20);
        pulse(301, 1200);
        check("recover_timeout", 32'(timeout), 0);
        check("recover_nvalid", 32'(n_valid), 9);
        pulse(301, 1200);
        check("recover2_nvalid", 32'(n_valid), 10);
        check_meas("recover", 9, 301, 1200);

        // Stuck low after running.
        drive(1'b0, 5000);
        check("stuckl_timeout", 32'(timeout), 1);
        check("stuckl_level", 32'(stuck_level), 0);
        check("stuckl_hold_high", 32'(high_cycles), 301);
        check("stuckl_nvalid", 32'(n_valid), 10);

        // Asynchronous reset in the middle of a high phase.
        pulse(301, 1200);
        drive(1'b1, 50);
        check("prereset_nvalid", 32'(n_valid), 11);
        #2 rst = 1'b1;
        #1;
        check("arst_high", 32'(high_cycles), 0);
        check("arst_period", 32'(period_cycles), 0);
        check("arst_valid", 32'(meas_valid), 0);
        check("arst_timeout", 32'(timeout), 0);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse(301, 1200);
        check("arst_arm_nvalid", 32'(n_valid), 11);
        pulse(301, 1200);
        check("arst_first_nvalid", 32'(n_valid), 12);
        check_meas("arst_first", 11, 301, 1200);

        // 2-cycle low glitch inside a 301-cycle high pulse.
        drive(1'b1, 100);
        drive(1'b0, 2);
        drive(1'b1, 199);
        drive(1'b0, 899);
        pulse(301, 1200);
        check("glitch_nvalid", 32'(n_valid), 32'(N_AFTER_GLITCH));
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        check_meas("glitch_filtered", 13, 301, 1200);
`else
        check_meas("glitch_short", 13, 100, 102);
        check_meas("glitch_rest", 14, 199, 1098);
`endif

        // Period exactly MAX_PERIOD: rise on the saturation cycle wins over timeout.
        pulse(301, 4096);
        pulse(301, 4096);
        check("maxp_timeout", 32'(timeout), 0);
        check("maxp_nvalid", 32'(n_valid), 32'(N_AFTER_GLITCH + 2));
        check_meas("maxp", N_AFTER_GLITCH + 1, 301, 4096);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
